// File: rtl/calc_acc_bank.sv
// calc_acc_bank: bank of accumulators driven by button strobes, with flags
// and a shift-add multiplier. Undo stack is built when CALC_UNDO_EN is defined.
module calc_acc_bank #(
    parameter int WIDTH      = 16,
    parameter int NUM_ACC    = 4,
    parameter int UNDO_DEPTH = 8,
    localparam int SW_SEL    = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1
) (
    input  logic              clk,
    input  logic              btnu,
    input  logic              btnd,
    input  logic [3:0]        op,
    input  logic [SW_SEL-1:0] acc_sel,
    input  logic [WIDTH-1:0]  sw,
    output logic [WIDTH-1:0]  led,
    output logic              busy,
    output logic              zero,
    output logic              ovf
);
    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = $clog2(WIDTH + 1);
    localparam int M   = WIDTH - 1;
    localparam logic [SW_SEL:0] ACC_N   = (SW_SEL + 1)'(NUM_ACC);
    localparam logic [CW-1:0]   MUL_END = CW'(WIDTH);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0011;
    localparam logic [3:0] OP_LT   = 4'b0100;
    localparam logic [3:0] OP_LSL  = 4'b0101;
    localparam logic [3:0] OP_SRA  = 4'b0110;
    localparam logic [3:0] OP_XOR  = 4'b0111;
    localparam logic [3:0] OP_MUL  = 4'b1000;
    localparam logic [3:0] OP_MOVE = 4'b1001;
    localparam logic [3:0] OP_UNDO = 4'b1010;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL} state_t;

    state_t              state;
    logic                btnd_q;
    logic [3:0]          op_q;
    logic [SW_SEL-1:0]   sel_q;
    logic                valid_q;
    logic [WIDTH-1:0]    a_q;
    logic [WIDTH-1:0]    b_q;
    logic [WIDTH-1:0]    acc [NUM_ACC];
    logic [2*WIDTH-1:0]  prod;
    logic [2*WIDTH-1:0]  mcand;
    logic [WIDTH-1:0]    mplier;
    logic [CW-1:0]       mcnt;

    logic                sel_ok;
    logic [WIDTH-1:0]    a_in;
    logic [WIDTH-1:0]    sum;
    logic [WIDTH-1:0]    diff;
    logic [WIDTH-1:0]    res;
    logic                res_ovf;
    logic                res_wr;
    logic                mul_done;

    assign sel_ok   = ({1'b0, acc_sel} < ACC_N);
    assign a_in     = sel_ok ? acc[acc_sel] : '0;
    assign led      = a_in;
    assign sum      = a_q + b_q;
    assign diff     = a_q - b_q;
    assign mul_done = (state == S_MUL) && (mcnt == MUL_END);

    // Single-cycle ALU result and whether the op commits at all
    always_comb begin
        res     = '0;
        res_ovf = 1'b0;
        res_wr  = 1'b1;
        unique case (op_q)
            OP_AND:  res = a_q & b_q;
            OP_OR:   res = a_q | b_q;
            OP_XOR:  res = a_q ^ b_q;
            OP_ADD: begin
                res     = sum;
                res_ovf = (a_q[M] == b_q[M]) && (sum[M] != a_q[M]);
            end
            OP_SUB: begin
                res     = diff;
                res_ovf = (a_q[M] != b_q[M]) && (diff[M] != a_q[M]);
            end
            OP_LT:   res = {{(WIDTH-1){1'b0}}, $signed(a_q) < $signed(b_q)};
            OP_LSL:  res = a_q << b_q[SHW-1:0];
            OP_SRA:  res = $unsigned($signed(a_q) >>> b_q[SHW-1:0]);
            OP_MOVE: res = b_q;
            default: res_wr = 1'b0;
        endcase
    end

`ifdef CALC_UNDO_EN
    localparam int UPW = (UNDO_DEPTH > 1) ? $clog2(UNDO_DEPTH) : 1;
    localparam int UCW = $clog2(UNDO_DEPTH + 1);
    localparam logic [UPW-1:0] U_LAST = UPW'(UNDO_DEPTH - 1);
    localparam logic [UCW-1:0] U_FULL = UCW'(UNDO_DEPTH);

    logic [SW_SEL-1:0] us_sel [UNDO_DEPTH];
    logic [WIDTH-1:0]  us_val [UNDO_DEPTH];
    logic [UPW-1:0]    u_wp;
    logic [UPW-1:0]    u_top;
    logic [UCW-1:0]    u_cnt;
    logic              push;
    logic              pop;

    assign u_top = (u_wp == '0) ? U_LAST : u_wp - 1'b1;
    assign push  = ((state == S_EXEC) && valid_q && res_wr) || mul_done;
    assign pop   = (state == S_EXEC) && valid_q
                   && (op_q == OP_UNDO) && (u_cnt != '0);

    // Circular undo stack: newest on top, oldest overwritten when full
    always_ff @(posedge clk) begin
        if (btnu) begin
            u_wp  <= '0;
            u_cnt <= '0;
        end else if (push) begin
            us_sel[u_wp] <= sel_q;
            us_val[u_wp] <= a_q;
            u_wp  <= (u_wp == U_LAST) ? '0 : u_wp + 1'b1;
            u_cnt <= (u_cnt == U_FULL) ? u_cnt : u_cnt + 1'b1;
        end else if (pop) begin
            u_wp  <= u_top;
            u_cnt <= u_cnt - 1'b1;
        end
    end
`endif

    // Control FSM, accumulators, flags and shift-add multiplier
    always_ff @(posedge clk) begin
        if (btnu) begin
            state   <= S_IDLE;
            btnd_q  <= 1'b0;
            busy    <= 1'b0;
            zero    <= 1'b0;
            ovf     <= 1'b0;
            op_q    <= '0;
            sel_q   <= '0;
            valid_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            prod    <= '0;
            mcand   <= '0;
            mplier  <= '0;
            mcnt    <= '0;
            for (int i = 0; i < NUM_ACC; i++) acc[i] <= '0;
        end else begin
            btnd_q <= btnd;
            unique case (state)
                S_IDLE: begin
                    if (btnd && !btnd_q) begin
                        op_q    <= op;
                        sel_q   <= acc_sel;
                        valid_q <= sel_ok;
                        a_q     <= a_in;
                        b_q     <= sw;
                        prod    <= '0;
                        mcand   <= {{WIDTH{1'b0}}, a_in};
                        mplier  <= sw;
                        mcnt    <= '0;
                        busy    <= 1'b1;
                        state   <= (op == OP_MUL && sel_ok) ? S_MUL : S_EXEC;
                    end
                end
                S_EXEC: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                    if (valid_q && res_wr) begin
                        acc[sel_q] <= res;
                        zero       <= (res == '0);
                        ovf        <= res_ovf;
                    end
`ifdef CALC_UNDO_EN
                    else if (pop) begin
                        acc[us_sel[u_top]] <= us_val[u_top];
                        zero <= (us_val[u_top] == '0);
                        ovf  <= 1'b0;
                    end
`endif
                end
                S_MUL: begin
                    if (mul_done) begin
                        acc[sel_q] <= prod[WIDTH-1:0];
                        zero  <= (prod[WIDTH-1:0] == '0);
                        ovf   <= |prod[2*WIDTH-1:WIDTH];
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        if (mplier[0]) prod <= prod + mcand;
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                        mcnt   <= mcnt + 1'b1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_calc_acc_bank.sv
// tb_calc_acc_bank: randomized and directed stimulus for calc_acc_bank,
// checked against an arithmetic reference model of the accumulator bank.
module tb_calc_acc_bank;
    localparam int W = 16;

    logic        clk = 1'b0;
    logic        btnu;
    logic        btnd;
    logic [3:0]  op;
    logic [1:0]  acc_sel;
    logic [15:0] sw;
    logic [15:0] led;
    logic        busy;
    logic        zero;
    logic        ovf;

    int checks = 0;
    int errors = 0;

    logic [15:0] m_acc [4];
    logic        m_zero;
    logic        m_ovf;
    logic [17:0] m_stk [$];

    calc_acc_bank dut (
        .clk     (clk),
        .btnu    (btnu),
        .btnd    (btnd),
        .op      (op),
        .acc_sel (acc_sel),
        .sw      (sw),
        .led     (led),
        .busy    (busy),
        .zero    (zero),
        .ovf     (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < 4; i++) m_acc[i] = '0;
        m_zero = 1'b0;
        m_ovf  = 1'b0;
        m_stk.delete();
    endtask

    task automatic m_apply(input logic [3:0] o, input int s,
                           input logic [15:0] b);
        logic [15:0] a;
        logic [15:0] r;
        logic        v;
        bit          wr;
        int          sa, sb, t, sh;
        longint      full;
        a  = m_acc[s];
        sa = int'($signed(a));
        sb = int'($signed(b));
        sh = int'(b[3:0]);
        r  = '0;
        v  = 1'b0;
        wr = 1'b1;
        case (o)
            4'd0: r = a & b;
            4'd1: r = a | b;
            4'd7: r = a ^ b;
            4'd2: begin
                t = sa + sb;
                r = 16'(t);
                v = (t > 32767) || (t < -32768);
            end
            4'd3: begin
                t = sa - sb;
                r = 16'(t);
                v = (t > 32767) || (t < -32768);
            end
            4'd4: r = (sa < sb) ? 16'd1 : 16'd0;
            4'd5: r = 16'(int'(a) << sh);
            4'd6: r = 16'(sa >>> sh);
            4'd8: begin
                full = longint'(a) * longint'(b);
                r = 16'(full);
                v = (full >> 16) != 0;
            end
            4'd9: r = b;
            default: wr = 1'b0;
        endcase
        if (wr) begin
`ifdef CALC_UNDO_EN
            m_stk.push_back({2'(s), a});
            if (m_stk.size() > 8) void'(m_stk.pop_front());
`endif
            m_acc[s] = r;
            m_zero   = (r == 0);
            m_ovf    = v;
        end
`ifdef CALC_UNDO_EN
        else if (o == 4'd10 && m_stk.size() > 0) begin
            logic [17:0] e;
            e = m_stk.pop_back();
            m_acc[e[17:16]] = e[15:0];
            m_zero = (e[15:0] == 0);
            m_ovf  = 1'b0;
        end
`endif
    endtask

    task automatic check_bank(input string tag);
        for (int i = 0; i < 4; i++) begin
            acc_sel = 2'(i);
            #1;
            check({tag, "_led"}, 32'(led), 32'(m_acc[i]));
        end
        check({tag, "_zero"}, 32'(zero), 32'(m_zero));
        check({tag, "_ovf"}, 32'(ovf), 32'(m_ovf));
    endtask

    task automatic run_op(input logic [3:0] o, input logic [1:0] s,
                          input logic [15:0] b, input bit glitch);
        int n;
        int bound;
        n = 0;
        bound = 0;
        @(negedge clk);
        op = o;
        acc_sel = s;
        sw = b;
        btnd = 1'b1;
        @(negedge clk);
        acc_sel = 2'($urandom);
        op = 4'($urandom);
        sw = 16'($urandom);
        while (busy && bound < 100) begin
            n++;
            if (glitch && n == 5) btnd = 1'b0;
            if (glitch && n == 6) btnd = 1'b1;
            @(negedge clk);
            bound++;
        end
        check("busy_cycles", 32'(n), (o == 4'd8) ? 32'(W + 1) : 32'd1);
        m_apply(o, int'(s), b);
        acc_sel = s;
        #1;
        check("led", 32'(led), 32'(m_acc[s]));
        check("zero", 32'(zero), 32'(m_zero));
        check("ovf", 32'(ovf), 32'(m_ovf));
        @(negedge clk);
        check("no_requeue", 32'(busy), 32'd0);
        btnd = 1'b0;
    endtask

    initial begin
        btnu = 1'b1;
        btnd = 1'b0;
        op = '0;
        acc_sel = '0;
        sw = '0;
        m_reset();
        repeat (2) @(negedge clk);
        btnu = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check_bank("rst");

        run_op(4'd2, 2'd0, 16'h354a, 1'b0);
        run_op(4'd3, 2'd0, 16'h1234, 1'b0);
        check("sub_val", 32'(m_acc[0]), 32'h2316);
        run_op(4'd9, 2'd1, 16'h7fff, 1'b0);
        run_op(4'd2, 2'd1, 16'h0001, 1'b0);
        check_bank("add_ovf");
        run_op(4'd9, 2'd2, 16'hff00, 1'b0);
        run_op(4'd4, 2'd2, 16'h0001, 1'b0);
        run_op(4'd0, 2'd2, 16'h0000, 1'b0);
        run_op(4'd9, 2'd2, 16'h0001, 1'b0);
        run_op(4'd5, 2'd2, 16'h0004, 1'b0);
        run_op(4'd9, 2'd3, 16'h8000, 1'b0);
        run_op(4'd6, 2'd3, 16'h0001, 1'b0);
        run_op(4'd9, 2'd0, 16'h0003, 1'b0);
        run_op(4'd8, 2'd0, 16'h0005, 1'b1);
        run_op(4'd9, 2'd1, 16'h8000, 1'b0);
        run_op(4'd8, 2'd1, 16'h0002, 1'b0);
        run_op(4'd15, 2'd1, 16'h1234, 1'b0);
        check_bank("directed");

        @(negedge clk);
        op = 4'd8;
        acc_sel = 2'd3;
        sw = 16'h0005;
        btnd = 1'b1;
        repeat (6) @(negedge clk);
        btnu = 1'b1;
        @(negedge clk);
        btnu = 1'b0;
        btnd = 1'b0;
        m_reset();
        check("midmul_busy", 32'(busy), 32'd0);
        check_bank("midmul_rst");
        run_op(4'd2, 2'd0, 16'h0001, 1'b0);

        run_op(4'd9, 2'd3, 16'h0010, 1'b0);
        run_op(4'd2, 2'd3, 16'h0005, 1'b0);
        run_op(4'd10, 2'd3, 16'h0000, 1'b0);
        run_op(4'd10, 2'd3, 16'h0000, 1'b0);
        check_bank("undo");

        for (int i = 0; i < 10; i++)
            run_op(4'd9, 2'($urandom), 16'($urandom), 1'b0);
        for (int i = 0; i < 9; i++)
            run_op(4'd10, 2'($urandom), 16'($urandom), 1'b0);
        check_bank("undo_deep");

        for (int i = 0; i < 150; i++) begin
            logic [3:0] ro;
            ro = 4'($urandom_range(0, 15));
            run_op(ro, 2'($urandom), 16'($urandom),
                   (ro == 4'd8) && ($urandom_range(0, 1) == 1));
            if (i % 10 == 0) check_bank("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
